// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared constants for the control sequencer: opcode encodings, ControlWord
//   bit positions, one-hot T-state values and a small helper that builds a
//   single-bit ControlWord mask.
package control_sequencer_pkg;

   localparam int CW_W = 12;
   localparam int OPC_W = 4;

   // Opcode encodings (instruction-register upper nibble)
   localparam logic [OPC_W-1:0] OP_LDA = 4'b0000;
   localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
   localparam logic [OPC_W-1:0] OP_SUB = 4'b0010;
   localparam logic [OPC_W-1:0] OP_OUT = 4'b1110;
   localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

   // ControlWord bit indices
   localparam int CW_ENABLE_PC  = 11;
   localparam int CW_INC_PC     = 10;
   localparam int CW_LATCH_MAR  = 9;
   localparam int CW_ENABLE_RAM = 8;
   localparam int CW_LATCH_IR   = 7;
   localparam int CW_ENABLE_IR  = 6;
   localparam int CW_LATCH_A    = 5;
   localparam int CW_ENABLE_A   = 4;
   localparam int CW_LATCH_B    = 3;
   localparam int CW_SUB_ALU    = 2;
   localparam int CW_ENABLE_ALU = 1;
   localparam int CW_LATCH_OUT  = 0;

   // One-hot T-state bit positions and values
   localparam int T1_IDX = 0;
   localparam int T2_IDX = 1;
   localparam int T3_IDX = 2;
   localparam int T4_IDX = 3;
   localparam int T5_IDX = 4;
   localparam int T6_IDX = 5;

   localparam logic [5:0] T1_OH = 6'b000001;
   localparam logic [5:0] T2_OH = 6'b000010;
   localparam logic [5:0] T3_OH = 6'b000100;
   localparam logic [5:0] T4_OH = 6'b001000;
   localparam logic [5:0] T5_OH = 6'b010000;
   localparam logic [5:0] T6_OH = 6'b100000;

   function automatic logic [CW_W-1:0] cw_bit(input int idx);
      logic [CW_W-1:0] w;
      w = '0;
      w[idx] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/control_sequencer_tstate_ring.sv
// tstate_ring
//   One-hot T-state ring counter. Clear loads T1, halt_set empties the ring
//   (all-zero while halted), otherwise the ring rotates one position per edge
//   while run_i=1 and halt_i=0, and holds otherwise.
// Ports
//   clk_i       clock
//   clear_i     synchronous active-high load of T1 (highest priority)
//   run_i       advance enable
//   halt_i      current halt flag; holds the ring
//   halt_set_i  empties the ring on this edge (leaving T4 of HLT)
//   tstate_o    one-hot T-state, bit0 = T1
module tstate_ring #(
   parameter int NUM_T_STATES = 6
) (
   input  logic                    clk_i,
   input  logic                    clear_i,
   input  logic                    run_i,
   input  logic                    halt_i,
   input  logic                    halt_set_i,
   output logic [NUM_T_STATES-1:0] tstate_o
);

   logic [NUM_T_STATES-1:0] tstate_q, tstate_d;

   always_comb begin
      tstate_d = tstate_q;
      if (halt_set_i) begin
         tstate_d = '0;
      end else if (run_i && !halt_i) begin
         tstate_d = {tstate_q[NUM_T_STATES-2:0], tstate_q[NUM_T_STATES-1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         tstate_q <= {{(NUM_T_STATES-1){1'b0}}, 1'b1};
      end else begin
         tstate_q <= tstate_d;
      end
   end

   assign tstate_o = tstate_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcode-free control sequencer for a simple accumulator machine. A
//   one-hot T-state ring steps through a six-state instruction cycle; the
//   opcode is captured on the T3->T4 edge and T4-T6 decode from that copy.
//   HLT sets a sticky halt flag on the edge leaving T4.
// Ports
//   MainClock    clock, rising-edge
//   Clear        synchronous active-high reset
//   Run          advance enable; low freezes the sequencer
//   Opcode       instruction-register upper nibble, valid from T3
//   TState       one-hot current T-state, all-zero while halted
//   ControlWord  decoded control lines, zero when Run=0 or halted
//   Halt         sticky halt flag
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int NUM_T_STATES = 6
) (
   input  logic                    MainClock,
   input  logic                    Clear,
   input  logic                    Run,
   input  logic [3:0]              Opcode,
   output logic [NUM_T_STATES-1:0] TState,
   output logic [11:0]             ControlWord,
   output logic                    Halt
);

   logic [OPC_W-1:0] opcode_q, opcode_d;
   logic             halt_q, halt_d;
   logic             advance;
   logic             halt_set;
   logic [CW_W-1:0]  cw;

   assign advance  = Run && !halt_q;
   assign halt_set = advance && TState[T4_IDX] && (opcode_q == OP_HLT);

   tstate_ring #(
      .NUM_T_STATES (NUM_T_STATES)
   ) u_tstate_ring (
      .clk_i      (MainClock),
      .clear_i    (Clear),
      .run_i      (Run),
      .halt_i     (halt_q),
      .halt_set_i (halt_set),
      .tstate_o   (TState)
   );

   always_comb begin
      opcode_d = opcode_q;
      halt_d   = halt_q;
      if (advance && TState[T3_IDX]) begin
         opcode_d = Opcode;
      end
      if (halt_set) begin
         halt_d = 1'b1;
      end
   end

   // Clear wins over a same-edge opcode capture and over the halt flag.
   always_ff @(posedge MainClock) begin
      if (Clear) begin
         opcode_q <= OP_LDA;
         halt_q   <= 1'b0;
      end else begin
         opcode_q <= opcode_d;
         halt_q   <= halt_d;
      end
   end

   // Each T-state drives at most one bus enable, so bus contention cannot
   // arise from this decode.
   always_comb begin
      cw = '0;
      if (advance) begin
         if (TState[T1_IDX]) begin
            cw = cw_bit(CW_ENABLE_PC) | cw_bit(CW_LATCH_MAR);
         end else if (TState[T2_IDX]) begin
            cw = cw_bit(CW_INC_PC);
         end else if (TState[T3_IDX]) begin
            cw = cw_bit(CW_ENABLE_RAM) | cw_bit(CW_LATCH_IR);
         end else if (TState[T4_IDX]) begin
            case (opcode_q)
               OP_LDA, OP_ADD, OP_SUB: cw = cw_bit(CW_ENABLE_IR) | cw_bit(CW_LATCH_MAR);
               OP_OUT:                 cw = cw_bit(CW_ENABLE_A) | cw_bit(CW_LATCH_OUT);
               default:                cw = '0;
            endcase
         end else if (TState[T5_IDX]) begin
            case (opcode_q)
               OP_LDA:         cw = cw_bit(CW_ENABLE_RAM) | cw_bit(CW_LATCH_A);
               OP_ADD, OP_SUB: cw = cw_bit(CW_ENABLE_RAM) | cw_bit(CW_LATCH_B);
               default:        cw = '0;
            endcase
         end else if (TState[T6_IDX]) begin
            case (opcode_q)
               OP_ADD:  cw = cw_bit(CW_ENABLE_ALU) | cw_bit(CW_LATCH_A);
               OP_SUB:  cw = cw_bit(CW_ENABLE_ALU) | cw_bit(CW_LATCH_A) | cw_bit(CW_SUB_ALU);
               default: cw = '0;
            endcase
         end
      end
   end

   assign ControlWord = cw;
   assign Halt        = halt_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   logic        clk;
   logic        clear;
   logic        run;
   logic [3:0]  opcode;
   logic [5:0]  tstate;
   logic [11:0] control_word;
   logic        halt;

   int total = 0;
   int bad   = 0;

   control_sequencer #(.NUM_T_STATES(6)) dut (
      .MainClock   (clk),
      .Clear       (clear),
      .Run         (run),
      .Opcode      (opcode),
      .TState      (tstate),
      .ControlWord (control_word),
      .Halt        (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row = inputs held for one cycle plus the outputs expected during
   // that cycle (before the edge that ends it).
   typedef struct {
      logic        clr;
      logic        rn;
      logic [3:0]  opc;
      logic [5:0]  ts;
      logic [11:0] cw;
      logic        hlt;
   } vec_t;

   typedef struct {
      logic [5:0]  ts;
      logic [11:0] cw;
      logic        hlt;
      string       name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic vec_t mk(input logic c, input logic r, input logic [3:0] o,
                               input logic [5:0] t, input logic [11:0] w, input logic h);
      vec_t v;
      v.clr = c; v.rn = r; v.opc = o; v.ts = t; v.cw = w; v.hlt = h;
      return v;
   endfunction

   task automatic step(input logic c, input logic r, input logic [3:0] o,
                       input logic [5:0] t, input logic [11:0] w, input logic h,
                       input string name);
      exp_t e;
      exp_t got;
      @(posedge clk);
      #1;
      clear  = c;
      run    = r;
      opcode = o;
      e.ts = t; e.cw = w; e.hlt = h; e.name = name;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         got = sb.pop_front();
         total++;
         if (tstate !== got.ts) begin
            bad++;
            $display("FAIL %s tstate got=%b want=%b", got.name, tstate, got.ts);
         end
         total++;
         if (control_word !== got.cw) begin
            bad++;
            $display("FAIL %s cw got=%h want=%h", got.name, control_word, got.cw);
         end
         total++;
         if (halt !== got.hlt) begin
            bad++;
            $display("FAIL %s halt got=%b want=%b", got.name, halt, got.hlt);
         end
      end
   endtask

   localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100,
                          T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

   initial begin
      clear  = 1'b1;
      run    = 1'b0;
      opcode = 4'h0;

      // LDA full cycle, fetch word right after reset
      vecs.push_back(mk(0, 1, 4'h0, T1, 12'hA00, 0));
      vecs.push_back(mk(0, 1, 4'h0, T2, 12'h400, 0));
      vecs.push_back(mk(0, 1, 4'h0, T3, 12'h180, 0));
      vecs.push_back(mk(0, 1, 4'h0, T4, 12'h240, 0));
      vecs.push_back(mk(0, 1, 4'h0, T5, 12'h120, 0));
      vecs.push_back(mk(0, 1, 4'h0, T6, 12'h000, 0));
      // SUB
      vecs.push_back(mk(0, 1, 4'h2, T1, 12'hA00, 0));
      vecs.push_back(mk(0, 1, 4'h2, T2, 12'h400, 0));
      vecs.push_back(mk(0, 1, 4'h2, T3, 12'h180, 0));
      vecs.push_back(mk(0, 1, 4'h2, T4, 12'h240, 0));
      vecs.push_back(mk(0, 1, 4'h2, T5, 12'h108, 0));
      vecs.push_back(mk(0, 1, 4'h2, T6, 12'h026, 0));
      // Run=0 in T2 for three cycles
      vecs.push_back(mk(0, 1, 4'h1, T1, 12'hA00, 0));
      vecs.push_back(mk(0, 0, 4'h1, T2, 12'h000, 0));
      vecs.push_back(mk(0, 0, 4'h1, T2, 12'h000, 0));
      vecs.push_back(mk(0, 0, 4'h1, T2, 12'h000, 0));
      vecs.push_back(mk(0, 1, 4'h1, T2, 12'h400, 0));
      vecs.push_back(mk(0, 1, 4'h1, T3, 12'h180, 0));
      // ADD with opcode changed to OUT during T5
      vecs.push_back(mk(0, 1, 4'h1, T4, 12'h240, 0));
      vecs.push_back(mk(0, 1, 4'hE, T5, 12'h108, 0));
      vecs.push_back(mk(0, 1, 4'hE, T6, 12'h022, 0));
      // OUT
      vecs.push_back(mk(0, 1, 4'hE, T1, 12'hA00, 0));
      vecs.push_back(mk(0, 1, 4'hE, T2, 12'h400, 0));
      vecs.push_back(mk(0, 1, 4'hE, T3, 12'h180, 0));
      vecs.push_back(mk(0, 1, 4'hE, T4, 12'h011, 0));
      vecs.push_back(mk(0, 1, 4'hE, T5, 12'h000, 0));
      vecs.push_back(mk(0, 1, 4'hE, T6, 12'h000, 0));
      // ADD, Clear during T5
      vecs.push_back(mk(0, 1, 4'h1, T1, 12'hA00, 0));
      vecs.push_back(mk(0, 1, 4'h1, T2, 12'h400, 0));
      vecs.push_back(mk(0, 1, 4'h1, T3, 12'h180, 0));
      vecs.push_back(mk(0, 1, 4'h1, T4, 12'h240, 0));
      vecs.push_back(mk(1, 1, 4'h1, T5, 12'h108, 0));
      // NOP 0101
      vecs.push_back(mk(0, 1, 4'h5, T1, 12'hA00, 0));
      vecs.push_back(mk(0, 1, 4'h5, T2, 12'h400, 0));
      vecs.push_back(mk(0, 1, 4'h5, T3, 12'h180, 0));
      vecs.push_back(mk(0, 1, 4'h5, T4, 12'h000, 0));
      vecs.push_back(mk(0, 1, 4'h5, T5, 12'h000, 0));
      vecs.push_back(mk(0, 1, 4'h5, T6, 12'h000, 0));
      // Clear beats a same-edge HLT capture in T3
      vecs.push_back(mk(0, 1, 4'hF, T1, 12'hA00, 0));
      vecs.push_back(mk(0, 1, 4'hF, T2, 12'h400, 0));
      vecs.push_back(mk(1, 1, 4'hF, T3, 12'h180, 0));
      // HLT
      vecs.push_back(mk(0, 1, 4'hF, T1, 12'hA00, 0));
      vecs.push_back(mk(0, 1, 4'hF, T2, 12'h400, 0));
      vecs.push_back(mk(0, 1, 4'hF, T3, 12'h180, 0));
      vecs.push_back(mk(0, 1, 4'h0, T4, 12'h000, 0));
      vecs.push_back(mk(0, 1, 4'h0, 6'b000000, 12'h000, 1));

      @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].clr, vecs[i].rn, vecs[i].opc, vecs[i].ts, vecs[i].cw, vecs[i].hlt,
              $sformatf("vec%0d", i));
      end

      // Halted: toggling Run/Opcode for 10 cycles changes nothing
      for (int i = 0; i < 10; i++) begin
         step(0, logic'(i % 2), 4'(i + 3), 6'b000000, 12'h000, 1, $sformatf("halt_hold%0d", i));
      end

      // Clear releases halt
      step(1, 1, 4'h0, 6'b000000, 12'h000, 1, "halt_clear");
      step(0, 1, 4'h0, T1, 12'hA00, 0, "after_clear_t1");
      step(0, 0, 4'h0, T2, 12'h000, 0, "after_clear_t2_frozen");

      // Run=0 in T3 must not capture; HLT presented while frozen, ADD when resumed
      step(0, 0, 4'hF, T2, 12'h000, 0, "frz_t2");
      step(0, 1, 4'hF, T2, 12'h400, 0, "resume_t2");
      step(0, 0, 4'hF, T3, 12'h000, 0, "frz_t3");
      step(0, 1, 4'h1, T3, 12'h180, 0, "resume_t3");
      step(0, 1, 4'hF, T4, 12'h240, 0, "add_t4");
      step(0, 1, 4'hF, T5, 12'h108, 0, "add_t5");
      step(0, 1, 4'hF, T6, 12'h022, 0, "add_t6");
      step(0, 1, 4'hF, T1, 12'hA00, 0, "wrap_t1");

      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one parameter: NUM_T_STATES, default 6, number of one-hot T-states per instruction cycle.
REQ-002 MainClock  input  1  the block's only clock; all state updates on its rising edge.
REQ-003 Clear  input  1  reset; synchronous and active-high.
REQ-004 Run  input  1  advance enable; low freezes the sequencer.
REQ-005 Opcode  input  4  instruction-register upper nibble; valid from T3 onward.
REQ-006 TState  output  6  one-hot current T-state, bit0 = T1 ... bit5 = T6; all-zero while halted.
REQ-007 ControlWord  output  12  bit map: [11] EnablePC, [10] IncPC, [9] LatchMAR, [8] EnableRAM, [7] LatchIR, [6] EnableIR, [5] LatchA, [4] EnableA, [3] LatchB, [2] SubAlu, [1] EnableAlu, [0] LatchOut.
REQ-008 Halt  output  1  sticky halt flag.

Function
REQ-009 The T-state counter SHALL advance T1->T2->...->T6->T1 by one position per rising edge when Run=1, Halt=0 and Clear=0.
REQ-010 The block SHALL capture Opcode into an internal opcode register on the T3->T4 edge only; T4-T6 decode SHALL use the captured value, not the live input.
REQ-011 ControlWord SHALL be a combinational decode of the registered T-state, the captured opcode, Run and Halt; it SHALL be all-zero whenever Run=0 or Halt=1.
REQ-012 Fetch, for every opcode: T1 = EnablePC+LatchMAR; T2 = IncPC; T3 = EnableRAM+LatchIR.
REQ-013 LDA (0000): T4 = EnableIR+LatchMAR; T5 = EnableRAM+LatchA; T6 = none.
REQ-014 ADD (0001): T4 = EnableIR+LatchMAR; T5 = EnableRAM+LatchB; T6 = EnableAlu+LatchA.
REQ-015 SUB (0010): same as ADD, plus SubAlu in T6 only.
REQ-016 OUT (1110): T4 = EnableA+LatchOut; T5 = none; T6 = none.
REQ-017 HLT (1111): T4 = none; on the edge leaving T4, Halt SHALL become 1 and TState SHALL become all-zero.
REQ-018 Any other opcode SHALL be a NOP: T4-T6 = none, with normal advance.
REQ-019 At most one of EnablePC, EnableRAM, EnableIR, EnableA, EnableAlu SHALL be 1 in any cycle.
REQ-020 While Halt=1, TState, the captured opcode and Halt SHALL hold regardless of Run and Opcode.
REQ-021 Run=0 SHALL hold TState and the captured opcode unchanged; resuming Run=1 SHALL continue from the held T-state.

Reset
REQ-022 When Clear=1 at a rising edge: TState=000001 (T1), Halt=0, captured opcode=0000.
REQ-023 Clear SHALL take priority over Run, Halt and any mid-instruction state, including a T3->T4 opcode capture in the same edge.
REQ-024 During the cycle after reset with Run=1, ControlWord SHALL be the T1 fetch word (EnablePC+LatchMAR).

Structure
REQ-025 A shared package SHALL hold the opcode constants (LDA, ADD, SUB, OUT, HLT), the ControlWord bit indices and the one-hot T-state constants.
REQ-026 The one-hot ring counter SHALL be a sub-module named tstate_ring with Run/Halt hold and Clear load-T1; decode SHALL stay in control_sequencer.

Verification
REQ-027 Clear then Run=1, Opcode=0000: T1..T6 give 0xA00, 0x400, 0x180, 0x240, 0x120, 0x000, then T1 again.
REQ-028 Opcode=0010 held through T3: T4 = 0x240, T5 = 0x108, T6 = 0x026 (EnableAlu+LatchA+SubAlu).
REQ-029 Opcode=1111: T4 ControlWord = 0x000; the next edge gives Halt=1 and TState=000000; 10 further cycles with toggling Run/Opcode leave both unchanged; Clear returns TState=000001, Halt=0.
REQ-030 Opcode changes from 0001 to 1110 during T5 -> T6 still decodes ADD (0x022); the change has no effect until the next T3->T4 capture.
REQ-031 Run=0 asserted in T2 for 3 cycles -> TState stays 000010 and ControlWord = 0x000; on Run=1, 0x400 appears, then T3.
REQ-032 Clear pulsed during T5 of ADD -> the next cycle shows TState = T1 and ControlWord = 0xA00; Opcode=0101 runs a full NOP cycle with T4-T6 = 0x000.
